ex_mm_pipe_reg: RTL and testbench

Parametrised EX→MM pipeline register with a valid/ready handshake, synchronous flush, and an optional two-entry skid buffer. It sits between the execute stage and the memory stage.

- It replaces the free-running EX/MM latch: back-pressure from a stalled memory stage is absorbed without losing instructions.
- A squashed instruction can never write registers or memory.
- A saturating stall counter feeds the performance-monitor block.

---
 rtl/ex_mm_pipe_reg.sv | 235 +++++++++++++++++++++++
 tb/tb_ex_mm_pipe_reg.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mm_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mm_pipe_reg
//  Purpose  : EX->MM pipeline register with valid/ready handshake,
//             synchronous flush, gated control outputs and a saturating
//             back-pressure counter for the performance monitor.
//  Build    : EX_MM_SKID_EN defined   -> two-entry skid buffer, registered
//                                        in_ready (no out_ready->in_ready path)
//             EX_MM_SKID_EN undefined -> single entry, in_ready combinational
//                                        from out_ready
//  Ports    :
//    clk, rst            clock (rising edge), async active-high reset
//    flush               synchronous squash of every held instruction
//    in_valid/in_ready   EX-side handshake
//    *_in                instruction payload and control bits from EX
//    out_valid/out_ready MM-side handshake
//    *_out               registered payload; control bits gated by out_valid
//    stall_clr           synchronous clear of stall_cycles
//    stall_cycles        saturating count of out_valid && !out_ready cycles
//  Revision : 1.0  initial release
// ============================================================================
module ex_mm_pipe_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   // EX side
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      reg_write_in,
   input  logic                      mem_read_in,
   input  logic                      mem_write_in,
   input  logic [2:0]                funct3_in,
   input  logic [DATA_WIDTH-1:0]     alu_result_in,
   input  logic [DATA_WIDTH-1:0]     write_data_in,
   input  logic [REG_ADDR_WIDTH-1:0] rd_in,
   // MM side
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      reg_write_out,
   output logic                      mem_read_out,
   output logic                      mem_write_out,
   output logic [2:0]                funct3_out,
   output logic [DATA_WIDTH-1:0]     alu_result_out,
   output logic [DATA_WIDTH-1:0]     write_data_out,
   output logic [REG_ADDR_WIDTH-1:0] rd_out,
   // performance monitor
   input  logic                      stall_clr,
   output logic [CNT_WIDTH-1:0]      stall_cycles
);

   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // One pipeline entry: payload and control travel together.
   typedef struct packed {
      logic                      reg_write;
      logic                      mem_read;
      logic                      mem_write;
      logic [2:0]                funct3;
      logic [DATA_WIDTH-1:0]     alu_result;
      logic [DATA_WIDTH-1:0]     write_data;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } entry_t;

   entry_t                 w_in_entry;
   entry_t                 main_q;
   entry_t                 main_d;
   logic                   w_main_valid;
   logic                   w_in_xfer;
   logic                   w_out_xfer;
   logic [CNT_WIDTH-1:0]   stall_q;
   logic [CNT_WIDTH-1:0]   stall_d;

   always_comb begin
      w_in_entry.reg_write  = reg_write_in;
      w_in_entry.mem_read   = mem_read_in;
      w_in_entry.mem_write  = mem_write_in;
      w_in_entry.funct3     = funct3_in;
      w_in_entry.alu_result = alu_result_in;
      w_in_entry.write_data = write_data_in;
      w_in_entry.rd         = rd_in;
   end

   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = w_main_valid & out_ready;

`ifdef EX_MM_SKID_EN
   // -------------------------------------------------------------------------
   // Two-entry skid buffer. State bits are {skid_valid, main_valid}, so the
   // valid flags fall straight out of the state register.
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t  state_q;
   state_t  state_d;
   entry_t  skid_q;
   entry_t  skid_d;
   logic    w_skid_valid;

   assign w_main_valid = state_q[0];
   assign w_skid_valid = state_q[1];

   // Decoded purely from flops: no combinational path from out_ready.
   assign in_ready = ~w_skid_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Only the valid bits clear; payload stays stale.
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (w_in_xfer) begin
                  state_d = ST_ONE;
                  main_d  = w_in_entry;
               end
            end
            ST_ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  main_d = w_in_entry;
               end else if (w_in_xfer) begin
                  // Main is stalled: the younger entry parks in skid.
                  state_d = ST_FULL;
                  skid_d  = w_in_entry;
               end else if (w_out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain case exists.
               if (w_out_xfer) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end
`else
   // -------------------------------------------------------------------------
   // Single entry. in_ready looks through to out_ready so a consumed entry
   // can be replaced in the same cycle (full throughput).
   // -------------------------------------------------------------------------
   logic valid_q;
   logic valid_d;

   assign w_main_valid = valid_q;
   assign in_ready     = ~valid_q | out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         main_q  <= '0;
      end else begin
         valid_q <= valid_d;
         main_q  <= main_d;
      end
   end

   always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (w_in_xfer) begin
         valid_d = 1'b1;
         main_d  = w_in_entry;
      end else if (w_out_xfer) begin
         valid_d = 1'b0;
      end
   end
`endif

   // -------------------------------------------------------------------------
   // Saturating stall counter. A flushed cycle is not a stall: the held
   // entry is being thrown away, not waiting.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (stall_clr) begin
         stall_d = '0;
      end else if (w_main_valid && !out_ready && !flush && (stall_q != c_CNT_MAX)) begin
         stall_d = stall_q + c_CNT_ONE;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. Control bits are gated so a bubble can never write.
   // -------------------------------------------------------------------------
   assign out_valid      = w_main_valid;
   assign reg_write_out  = main_q.reg_write & w_main_valid;
   assign mem_read_out   = main_q.mem_read  & w_main_valid;
   assign mem_write_out  = main_q.mem_write & w_main_valid;
   assign funct3_out     = main_q.funct3;
   assign alu_result_out = main_q.alu_result;
   assign write_data_out = main_q.write_data;
   assign rd_out         = main_q.rd;
   assign stall_cycles   = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mm_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mm_pipe_reg
//  Purpose  : Self-checking bench for ex_mm_pipe_reg (CNT_WIDTH = 4).
//             A queue model of held entries and a counter model are updated
//             every falling edge; table rows and hand sequences add explicit
//             checks. Works for both EX_MM_SKID_EN builds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mm_pipe_reg;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;
`ifdef EX_MM_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          reg_write_in = 1'b0;
   logic          mem_read_in = 1'b0;
   logic          mem_write_in = 1'b0;
   logic [2:0]    funct3_in = '0;
   logic [DW-1:0] alu_result_in = '0;
   logic [DW-1:0] write_data_in = '0;
   logic [AW-1:0] rd_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          reg_write_out;
   logic          mem_read_out;
   logic          mem_write_out;
   logic [2:0]    funct3_out;
   logic [DW-1:0] alu_result_out;
   logic [DW-1:0] write_data_out;
   logic [AW-1:0] rd_out;
   logic          stall_clr = 1'b0;
   logic [CW-1:0] stall_cycles;

   ex_mm_pipe_reg #(
      .DATA_WIDTH     (DW),
      .REG_ADDR_WIDTH (AW),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .reg_write_in   (reg_write_in),
      .mem_read_in    (mem_read_in),
      .mem_write_in   (mem_write_in),
      .funct3_in      (funct3_in),
      .alu_result_in  (alu_result_in),
      .write_data_in  (write_data_in),
      .rd_in          (rd_in),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .reg_write_out  (reg_write_out),
      .mem_read_out   (mem_read_out),
      .mem_write_out  (mem_write_out),
      .funct3_out     (funct3_out),
      .alu_result_out (alu_result_out),
      .write_data_out (write_data_out),
      .rd_out         (rd_out),
      .stall_clr      (stall_clr),
      .stall_cycles   (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          rw;
      logic          mr;
      logic          mw;
      logic [2:0]    f3;
      logic [DW-1:0] alu;
      logic [DW-1:0] wd;
      logic [AW-1:0] rd;
   } entry_t;

   typedef struct {
      logic          iv;
      logic          ordy;
      logic [DW-1:0] alu;
      logic          exp_ov;
      logic [DW-1:0] exp_alu;
   } vec_t;

   entry_t sb_q[$];
   entry_t e_pop;
   entry_t e_push;
   int     cnt_m   = 0;
   int     n_pass  = 0;
   int     n_total = 0;
   int     acc_cnt = 0;
   int     pop_cnt = 0;
   logic   exp_rdy;
   vec_t   tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Drive one cycle's inputs just after the rising edge.
   task automatic drive(input logic iv, input logic ordy, input logic [DW-1:0] alu,
                        input logic mw, input logic fl, input logic clr);
      @(posedge clk);
      #1;
      in_valid      = iv;
      out_ready     = ordy;
      alu_result_in = alu;
      write_data_in = ~alu;
      funct3_in     = alu[2:0];
      rd_in         = alu[4:0] ^ 5'h05;
      reg_write_in  = alu[0];
      mem_read_in   = alu[1];
      mem_write_in  = mw;
      flush         = fl;
      stall_clr     = clr;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Scoreboard / reference model, evaluated mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         cnt_m = 0;
      end else begin
`ifdef EX_MM_SKID_EN
         exp_rdy = (sb_q.size() < 2);
`else
         exp_rdy = (sb_q.size() == 0) || out_ready;
`endif
         chk("out_valid", 32'(out_valid), 32'(sb_q.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("stall_cycles", 32'(stall_cycles), 32'(cnt_m));
         if (sb_q.size() == 0)
            chk("ctrl_gated", 32'({reg_write_out, mem_read_out, mem_write_out}), 32'd0);

         if (stall_clr) cnt_m = 0;
         else if ((sb_q.size() > 0) && !out_ready && !flush && (cnt_m < CNT_MAX)) cnt_m++;

         if (flush) begin
            sb_q.delete();
         end else begin
            if ((sb_q.size() > 0) && out_ready) begin
               e_pop = sb_q.pop_front();
               pop_cnt++;
               chk("alu_result_out", alu_result_out, e_pop.alu);
               chk("write_data_out", write_data_out, e_pop.wd);
               chk("rd_out", 32'(rd_out), 32'(e_pop.rd));
               chk("funct3_out", 32'(funct3_out), 32'(e_pop.f3));
               chk("ctrl_out", 32'({reg_write_out, mem_read_out, mem_write_out}),
                   32'({e_pop.rw, e_pop.mr, e_pop.mw}));
            end
            if (in_valid && exp_rdy) begin
               e_push.rw  = reg_write_in;
               e_push.mr  = mem_read_in;
               e_push.mw  = mem_write_in;
               e_push.f3  = funct3_in;
               e_push.alu = alu_result_in;
               e_push.wd  = write_data_in;
               e_push.rd  = rd_in;
               sb_q.push_back(e_push);
               acc_cnt++;
            end
         end
      end
   end

   initial begin
      // Streaming table: 8 back-to-back entries, then idle.
      for (int i = 0; i < 10; i++) begin
         tbl[i].iv      = (i < 8);
         tbl[i].ordy    = 1'b1;
         tbl[i].alu     = 32'h10 + 32'(i);
         tbl[i].exp_ov  = (i >= 1) && (i <= 8);
         tbl[i].exp_alu = 32'h10 + 32'(i) - 32'd1;
      end

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_alu_out", alu_result_out, 32'd0);
      chk("rst_ctrl", 32'({reg_write_out, mem_read_out, mem_write_out}), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].iv, tbl[i].ordy, tbl[i].alu, 1'b0, 1'b0, 1'b0);
         settle();
         chk("stream_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
         if (tbl[i].exp_ov) chk("stream_alu", alu_result_out, tbl[i].exp_alu);
         chk("stream_stall", 32'(stall_cycles), 32'd0);
      end

      // Back-pressure: one accepted entry, then 4 stalled cycles.
      settle();
      acc_cnt = 0;
      drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 32'h21 + 32'(k), 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("bp_accepted", 32'(acc_cnt), 32'(CAP));
      pop_cnt = 0;
      settle();
      chk("bp_stall4", 32'(stall_cycles), 32'd4);
      repeat (3) drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("bp_drained", 32'(pop_cnt), 32'(CAP));
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Flush in the fullest state, mem_write set on every entry.
      drive(1'b1, 1'b0, 32'h30, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 32'h31, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'h32, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_memwr", 32'(mem_write_out), 32'd0);
      chk("flush_ready", 32'(in_ready), 32'd1);

      // Flush discarding a same-cycle input transfer.
      drive(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'h41, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("flush_xfer_drop", 32'(out_valid), 32'd0);

      // Async reset in the middle of a stall.
      drive(1'b1, 1'b0, 32'h55, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 32'h56, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_ctrl", 32'({reg_write_out, mem_read_out, mem_write_out}), 32'd0);
      chk("arst_alu", alu_result_out, 32'd0);
      chk("arst_wdata", write_data_out, 32'd0);
      chk("arst_rd_f3", 32'({rd_out, funct3_out}), 32'd0);
      chk("arst_stall", 32'(stall_cycles), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("arst_no_xfer", 32'(out_valid), 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;

      // Saturation at 2^CW-1, then clear during an active stall.
      drive(1'b1, 1'b0, 32'h60, 1'b0, 1'b0, 1'b0);
      repeat (20) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("sat_hold", 32'(stall_cycles), 32'(CNT_MAX));
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("sat_clr", 32'(stall_cycles), 32'd0);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("end_empty", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
